// File: rtl/ex_ic_arbiter.sv
// Execute-to-complete arbiter: per-lane result FIFOs drained one per cycle by round-robin
// into a registered packet. Optional EX_IC_PERF_EN adds stall/done performance counters.
module ex_ic_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int LANE_DEPTH = 2,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 5,
  parameter int XLEN       = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*PREG_W-1:0] fu_dest_preg,
  input  logic [NUM_FU*ROB_W-1:0]  fu_rob_idx,
  input  logic [NUM_FU-1:0]        fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]   fu_result,
  input  logic [NUM_FU*XLEN-1:0]   fu_rs2_value,
  output logic                     ex_ic_valid,
  output logic [PREG_W-1:0]        ex_ic_dest_preg,
  output logic [ROB_W-1:0]         ex_ic_rob_idx,
  output logic                     ex_ic_take_branch,
  output logic [XLEN-1:0]          ex_ic_result,
  output logic [XLEN-1:0]          ex_ic_rs2_value
`ifdef EX_IC_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_done_cnt
`endif
);

  localparam int PTR_W = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int CNT_W = $clog2(LANE_DEPTH + 1);
  localparam int RR_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic [PREG_W-1:0] dest_preg;
    logic [ROB_W-1:0]  rob_idx;
    logic              take_branch;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   rs2_value;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LANE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  entry_t            head [NUM_FU];
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              win_found;
  logic [RR_W-1:0]   win_idx;
  logic [RR_W:0]     scan;
  logic [RR_W-1:0]   rr_ptr_reg;
  entry_t            out_reg;
  logic              out_valid_reg;

  // Round-robin scan starting at rr_ptr; only already-stored entries are eligible.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr_reg} + (RR_W+1)'(k);
      if (scan >= (RR_W+1)'(NUM_FU)) scan = scan - (RR_W+1)'(NUM_FU);
      if (!win_found && nonempty[scan[RR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[RR_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_lane
    entry_t           mem [LANE_DEPTH];
    entry_t           in_entry;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W-1:0] rptr_reg;

    assign in_entry = {fu_dest_preg[gi*PREG_W +: PREG_W], fu_rob_idx[gi*ROB_W +: ROB_W],
                       fu_take_branch[gi], fu_result[gi*XLEN +: XLEN],
                       fu_rs2_value[gi*XLEN +: XLEN]};
    // Readiness comes from registered occupancy only, so a full lane stays not-ready while popping.
    assign fu_ready[gi] = reset & (count_reg < CNT_W'(LANE_DEPTH));
    assign push[gi]     = fu_valid[gi] & fu_ready[gi] & ~squash;
    assign pop[gi]      = win_found && (win_idx == RR_W'(gi));
    assign nonempty[gi] = (count_reg != '0);
    assign head[gi]     = mem[rptr_reg];

    always_ff @(posedge clock) begin
      if (push[gi]) mem[wptr_reg] <= in_entry;
    end

    always_ff @(posedge clock) begin
      if (!reset || squash) begin
        count_reg <= '0;
        wptr_reg  <= '0;
        rptr_reg  <= '0;
      end else begin
        if (push[gi]) wptr_reg <= ptr_inc(wptr_reg);
        if (pop[gi])  rptr_reg <= ptr_inc(rptr_reg);
        case ({push[gi], pop[gi]})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      rr_ptr_reg    <= '0;
    end else if (win_found) begin
      out_valid_reg <= 1'b1;
      out_reg       <= head[win_idx];
      rr_ptr_reg    <= (win_idx == RR_W'(NUM_FU - 1)) ? '0 : win_idx + RR_W'(1);
    end else begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end
  end

  assign ex_ic_valid       = out_valid_reg;
  assign ex_ic_dest_preg   = out_reg.dest_preg;
  assign ex_ic_rob_idx     = out_reg.rob_idx;
  assign ex_ic_take_branch = out_reg.take_branch;
  assign ex_ic_result      = out_reg.result;
  assign ex_ic_rs2_value   = out_reg.rs2_value;

`ifdef EX_IC_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] done_cnt_reg;

  // Saturating counters; squash intentionally leaves them alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      done_cnt_reg  <= '0;
    end else begin
      if (|(fu_valid & ~fu_ready) && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (out_valid_reg && done_cnt_reg != '1)            done_cnt_reg  <= done_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_done_cnt  = done_cnt_reg;
`endif

endmodule
